tcdm_bank_responder: RTL and testbench

- Memory-side responder for one TCDM bank port of the cluster heterogeneous interconnect.
- Accepts word requests from the interconnect's bank-facing master port, grants them, and drives a single-port SRAM macro.
- Returns read data, ID and a response valid exactly one cycle after the grant.
- Implements the test-and-set atomic in two phases: read the old value, then write all-ones. It also keeps saturating per-bank access counters for performance monitoring.

---
 rtl/tcdm_bank_pkg.sv | 18 +
 rtl/tcdm_sat_counter.sv | 34 +++
 rtl/tcdm_bank_responder.sv | 143 ++++++++++++++
 tb/tb_tcdm_bank_responder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_bank_pkg.sv
// Shared types and constants for the TCDM bank responder.
// Holds the FSM state type, the test-and-set flag position and the TAS fill pattern.
package tcdm_bank_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StTasWr
    } bank_state_e;

    // Test-and-set writes every bit of the word to this value.
    localparam logic TasFillBit = 1'b1;

    // The test-and-set flag rides on the MSB of the request address.
    function automatic int unsigned tas_flag_pos(input int unsigned aw);
        return aw - 1;
    endfunction

endpackage

// File: rtl/tcdm_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Clear wins over a same-cycle increment.
module tcdm_sat_counter #(
    parameter int unsigned CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {CW{1'b1}})) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tcdm_bank_responder.sv
// Memory-side responder for one TCDM bank: grants word requests, drives the SRAM,
// returns one-cycle-latency responses and performs two-phase test-and-set.
module tcdm_bank_responder
    import tcdm_bank_pkg::*;
#(
    parameter int unsigned ADDR_MEM_WIDTH = 11,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BE_WIDTH       = DATA_WIDTH / 8,
    parameter int unsigned IW             = 20,
    parameter int unsigned AW             = ADDR_MEM_WIDTH + 3,
    parameter int unsigned CW             = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [AW-1:0]             add_i,
    input  logic                      wen_i,
    input  logic [BE_WIDTH-1:0]       be_i,
    input  logic [DATA_WIDTH-1:0]     data_i,
    input  logic [IW-1:0]             id_i,
    output logic                      r_valid_o,
    output logic [DATA_WIDTH-1:0]     r_data_o,
    output logic [IW-1:0]             r_id_o,
    output logic                      sram_req_o,
    output logic                      sram_we_o,
    output logic [ADDR_MEM_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0]     sram_wdata_o,
    output logic [BE_WIDTH-1:0]       sram_be_o,
    input  logic [DATA_WIDTH-1:0]     sram_rdata_i,
    output logic [CW-1:0]             cnt_rd_o,
    output logic [CW-1:0]             cnt_wr_o,
    output logic [CW-1:0]             cnt_tas_o
);

    localparam int unsigned TasBit = tas_flag_pos(AW);

    bank_state_e               state_q, state_d;
    logic [ADDR_MEM_WIDTH-1:0] tas_addr_q;
    logic                      rsp_valid_q;
    logic                      rsp_wr_q;
    logic [IW-1:0]             rsp_id_q;

    logic grant;
    logic rd_grant;
    logic wr_grant;
    logic tas_grant;
    logic unused_byte_offset;

    assign unused_byte_offset = ^add_i[1:0];

    assign gnt_o     = (state_q == StIdle) && !rst_i;
    assign grant     = req_i & gnt_o;
    assign wr_grant  = grant & ~wen_i;
    assign rd_grant  = grant & wen_i & ~add_i[TasBit];
    assign tas_grant = grant & wen_i & add_i[TasBit];

    always_comb begin
        state_d      = state_q;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = add_i[AW-2:2];
        sram_wdata_o = data_i;
        sram_be_o    = be_i;
        unique case (state_q)
            StIdle: begin
                sram_req_o = grant;
                sram_we_o  = ~wen_i;
                if (tas_grant) begin
                    state_d = StTasWr;
                end
            end
            StTasWr: begin
                // Reset here drops the all-ones write so the word keeps its old value.
                sram_req_o   = ~rst_i;
                sram_we_o    = 1'b1;
                sram_addr_o  = tas_addr_q;
                sram_wdata_o = {DATA_WIDTH{TasFillBit}};
                sram_be_o    = {BE_WIDTH{TasFillBit}};
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            tas_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= grant;
            rsp_wr_q    <= wr_grant;
            if (tas_grant) begin
                tas_addr_q <= add_i[AW-2:2];
            end
            if (grant) begin
                rsp_id_q <= id_i;
            end
        end
    end

    assign r_valid_o = rsp_valid_q & ~rst_i;
    assign r_id_o    = rsp_id_q;
    assign r_data_o  = (r_valid_o && !rsp_wr_q) ? sram_rdata_i : '0;

    tcdm_sat_counter #(
        .CW(CW)
    ) u_cnt_rd (
        .clk  (clk_i),
        .rst  (rst_i),
        .clear(clear_i),
        .inc  (rd_grant),
        .count(cnt_rd_o)
    );

    tcdm_sat_counter #(
        .CW(CW)
    ) u_cnt_wr (
        .clk  (clk_i),
        .rst  (rst_i),
        .clear(clear_i),
        .inc  (wr_grant),
        .count(cnt_wr_o)
    );

    tcdm_sat_counter #(
        .CW(CW)
    ) u_cnt_tas (
        .clk  (clk_i),
        .rst  (rst_i),
        .clear(clear_i),
        .inc  (tas_grant),
        .count(cnt_tas_o)
    );

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Directed bench for tcdm_bank_responder with an SRAM model, a reference memory
// and a response scoreboard.
module tb_tcdm_bank_responder;

    localparam int unsigned AMW = 11;
    localparam int unsigned DW  = 32;
    localparam int unsigned BEW = 4;
    localparam int unsigned IW  = 20;
    localparam int unsigned AW  = 14;
    localparam int unsigned CW  = 4;
    localparam int          CntMax = 15;

    logic           clk = 1'b0;
    logic           rst, clear, req, gnt, wen;
    logic [AW-1:0]  add;
    logic [BEW-1:0] be;
    logic [DW-1:0]  data;
    logic [IW-1:0]  id;
    logic           r_valid;
    logic [DW-1:0]  r_data;
    logic [IW-1:0]  r_id;
    logic           sram_req, sram_we;
    logic [AMW-1:0] sram_addr;
    logic [DW-1:0]  sram_wdata;
    logic [BEW-1:0] sram_be;
    logic [DW-1:0]  sram_rdata = '0;
    logic [CW-1:0]  cnt_rd, cnt_wr, cnt_tas;

    always #5 clk = ~clk;

    tcdm_bank_responder #(
        .ADDR_MEM_WIDTH(AMW),
        .DATA_WIDTH    (DW),
        .BE_WIDTH      (BEW),
        .IW            (IW),
        .AW            (AW),
        .CW            (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .req_i       (req),
        .gnt_o       (gnt),
        .add_i       (add),
        .wen_i       (wen),
        .be_i        (be),
        .data_i      (data),
        .id_i        (id),
        .r_valid_o   (r_valid),
        .r_data_o    (r_data),
        .r_id_o      (r_id),
        .sram_req_o  (sram_req),
        .sram_we_o   (sram_we),
        .sram_addr_o (sram_addr),
        .sram_wdata_o(sram_wdata),
        .sram_be_o   (sram_be),
        .sram_rdata_i(sram_rdata),
        .cnt_rd_o    (cnt_rd),
        .cnt_wr_o    (cnt_wr),
        .cnt_tas_o   (cnt_tas)
    );

    // Single-port SRAM macro model: one-cycle read latency, byte-enabled writes.
    logic [DW-1:0] mem [2**AMW] = '{default: '0};
    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < BEW; b++) begin
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          sb[$];
    logic [DW-1:0] ref_mem [2**AMW] = '{default: '0};
    int errors = 0, checks = 0, pushed = 0, seen = 0;
    int e_rd = 0, e_wr = 0, e_tas = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CntMax) ? CntMax : v + 1;
    endfunction

    // Response monitor: every r_valid must match the oldest expected response.
    always @(negedge clk) begin
        rsp_t e;
        if (r_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(r_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                seen++;
                chk("rsp_id", 32'(r_id), 32'(e.id));
                chk("rsp_data", r_data, e.data);
            end
        end
    end

    task automatic issue(input logic wen_v, input logic tas, input logic [AMW-1:0] w,
                         input logic [BEW-1:0] be_v, input logic [DW-1:0] d,
                         input logic [IW-1:0] id_v, input logic exp_gnt, input logic clr);
        rsp_t e;
        @(posedge clk);
        #1;
        req   = 1'b1;
        wen   = wen_v;
        add   = {tas, w, 2'b10};
        be    = be_v;
        data  = d;
        id    = id_v;
        clear = clr;
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        if (exp_gnt) begin
            chk("sram_req", 32'(sram_req), 32'd1);
            chk("sram_we", 32'(sram_we), 32'(!wen_v));
            chk("sram_addr", 32'(sram_addr), 32'(w));
            e.id = id_v;
            if (!wen_v) begin
                chk("sram_wdata", sram_wdata, d);
                chk("sram_be", 32'(sram_be), 32'(be_v));
                e.data = '0;
                for (int b = 0; b < BEW; b++) begin
                    if (be_v[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
                end
                e_wr = sat_inc(e_wr);
            end else begin
                e.data = ref_mem[w];
                if (tas) begin
                    ref_mem[w] = '1;
                    e_tas = sat_inc(e_tas);
                end else begin
                    e_rd = sat_inc(e_rd);
                end
            end
            sb.push_back(e);
            pushed++;
        end
        if (clr) begin
            e_rd  = 0;
            e_wr  = 0;
            e_tas = 0;
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        req   = 1'b0;
        clear = 1'b0;
        wen   = 1'b1;
        add   = '0;
        @(negedge clk);
    endtask

    task automatic chk_taswr(input logic [AMW-1:0] w);
        chk("taswr_gnt", 32'(gnt), 32'd0);
        chk("taswr_req", 32'(sram_req), 32'd1);
        chk("taswr_we", 32'(sram_we), 32'd1);
        chk("taswr_addr", 32'(sram_addr), 32'(w));
        chk("taswr_wdata", sram_wdata, 32'hFFFF_FFFF);
        chk("taswr_be", 32'(sram_be), 32'hF);
    endtask

    task automatic chk_cnt();
        chk("cnt_rd", 32'(cnt_rd), 32'(e_rd));
        chk("cnt_wr", 32'(cnt_wr), 32'(e_wr));
        chk("cnt_tas", 32'(cnt_tas), 32'(e_tas));
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; req = 1'b0; wen = 1'b1;
        add = '0; be = '0; data = '0; id = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_sram_req", 32'(sram_req), 32'd0);
        chk("rst_r_valid", 32'(r_valid), 32'd0);
        chk("rst_r_id", 32'(r_id), 32'd0);
        chk("rst_r_data", r_data, 32'd0);
        chk_cnt();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_gnt", 32'(gnt), 32'd1);

        // Plain writes and read-back
        issue(1'b0, 1'b0, 11'h010, 4'hF, 32'hDEAD_BEEF, 20'h5, 1'b1, 1'b0);
        idle();
        chk_cnt();
        issue(1'b0, 1'b0, 11'h030, 4'hF, 32'h1234_5678, 20'h6, 1'b1, 1'b0);
        idle();
        issue(1'b1, 1'b0, 11'h010, 4'hF, 32'h0, 20'h7, 1'b1, 1'b0);
        idle();
        idle();
        chk("rid_hold", 32'(r_id), 32'h7);
        chk("rdata_idle", r_data, 32'd0);
        chk_cnt();

        // Test-and-set twice on the same word
        issue(1'b1, 1'b1, 11'h020, 4'h1, 32'h0, 20'h9, 1'b1, 1'b0);
        idle();
        chk_taswr(11'h020);
        idle();
        issue(1'b1, 1'b1, 11'h020, 4'hF, 32'h0, 20'hA, 1'b1, 1'b0);
        idle();
        chk_taswr(11'h020);
        idle();
        chk_cnt();

        // Streaming reads with req held high
        issue(1'b1, 1'b0, 11'h010, 4'hF, 32'h0, 20'h11, 1'b1, 1'b0);
        issue(1'b1, 1'b0, 11'h020, 4'hF, 32'h0, 20'h12, 1'b1, 1'b0);
        issue(1'b1, 1'b0, 11'h030, 4'hF, 32'h0, 20'h13, 1'b1, 1'b0);
        issue(1'b1, 1'b0, 11'h040, 4'hF, 32'h0, 20'h14, 1'b1, 1'b0);
        idle();
        idle();
        chk_cnt();

        // TS-flagged write behaves as a plain partial write
        issue(1'b0, 1'b1, 11'h040, 4'h3, 32'hCAFE_F00D, 20'h15, 1'b1, 1'b0);
        idle();
        issue(1'b1, 1'b0, 11'h040, 4'hF, 32'h0, 20'h16, 1'b1, 1'b0);
        idle();
        idle();
        chk_cnt();

        // Back-to-back TAS: grants in cycles 0 and 2
        issue(1'b1, 1'b1, 11'h050, 4'hF, 32'h0, 20'h21, 1'b1, 1'b0);
        issue(1'b1, 1'b1, 11'h051, 4'hF, 32'h0, 20'h22, 1'b0, 1'b0);
        chk_taswr(11'h050);
        issue(1'b1, 1'b1, 11'h051, 4'hF, 32'h0, 20'h22, 1'b1, 1'b0);
        idle();
        chk_taswr(11'h051);
        idle();
        chk_cnt();

        // Reset in the TAS_WR cycle aborts the write and the response
        @(posedge clk);
        #1;
        req = 1'b1; wen = 1'b1; add = {1'b1, 11'h030, 2'b00}; id = 20'h33;
        @(negedge clk);
        chk("rst_tas_gnt", 32'(gnt), 32'd1);
        @(posedge clk);
        #1;
        req = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_taswr_sram_req", 32'(sram_req), 32'd0);
        chk("rst_taswr_r_valid", 32'(r_valid), 32'd0);
        e_rd = 0; e_wr = 0; e_tas = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst2_r_valid", 32'(r_valid), 32'd0);
        chk("rst2_r_id", 32'(r_id), 32'd0);
        chk("rst2_r_data", r_data, 32'd0);
        chk_cnt();
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(1'b1, 1'b0, 11'h030, 4'hF, 32'h0, 20'h34, 1'b1, 1'b0);
        idle();
        idle();

        // Counter saturation and clear priority
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 1'b0, 11'(256 + i), 4'hF, 32'(i), 20'(64 + i), 1'b1, 1'b0);
        end
        idle();
        chk("cnt_wr_sat", 32'(cnt_wr), 32'd15);
        chk_cnt();
        issue(1'b0, 1'b0, 11'h1FF, 4'hF, 32'h5555_AAAA, 20'h3F, 1'b1, 1'b1);
        idle();
        chk("cnt_wr_clear", 32'(cnt_wr), 32'd0);
        chk_cnt();
        idle();
        chk("rsp_total", 32'(seen), 32'(pushed));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
